// File: rtl/lc3_alu_pkg.sv
// Shared definitions for the LC-3 sequential execute stage: ALU op codes,
// FSM state type, multiply iteration count and the imm5 sign extender.
package lc3_alu_pkg;

    localparam logic [2:0] ALUK_ADD   = 3'b000;
    localparam logic [2:0] ALUK_AND   = 3'b001;
    localparam logic [2:0] ALUK_NOT   = 3'b010;
    localparam logic [2:0] ALUK_PASSA = 3'b011;
    localparam logic [2:0] ALUK_MUL   = 3'b100;

    localparam int MUL_ITERS = 16;
    localparam int ITER_W    = $clog2(MUL_ITERS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [15:0] sext(input logic [4:0] imm);
        return {{11{imm[4]}}, imm};
    endfunction

endpackage

// File: rtl/lc3_mul_iter.sv
// Iterative shift-add multiplier, one bit of the multiplier per step, LSB first.
// product_o presents the accumulator including the current step's partial product.
module lc3_mul_iter
    import lc3_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] product_o
);

    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  acc_next;

    always_comb begin
        acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
            cnt_d    = '0;
        end else if (step_i) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign last_o    = (cnt_q == ITER_W'(MUL_ITERS - 1));
    assign product_o = acc_next;

endmodule

// File: rtl/lc3_alu_seq.sv
// LC-3 sequential execute stage: registered ADD/AND/NOT/PASSA result with NZP.
// Define LC3_MUL_EN to compile in the 16-cycle iterative multiply (aluk = 100).
module lc3_alu_seq
    import lc3_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             start,
    input  logic [2:0]       aluk,
    input  logic [WIDTH-1:0] sr1,
    input  logic [WIDTH-1:0] sr2,
    input  logic             imm_sel,
    input  logic [4:0]       imm5,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       nzp
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [2:0]       aluk_q, aluk_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       nzp_q, nzp_d;
    logic [WIDTH-1:0] opb_in;
    logic [WIDTH-1:0] alu_res;
    logic             is_mul;

    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1])
            return 3'b100;
        else if (v == '0)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    assign opb_in = imm_sel ? WIDTH'(sext(imm5)) : sr2;

`ifdef LC3_MUL_EN
    logic             mul_load, mul_step, mul_last;
    logic [WIDTH-1:0] mul_prod;

    assign is_mul   = (aluk == ALUK_MUL);
    assign mul_load = (state_q == ST_IDLE) && start && is_mul;
    assign mul_step = (state_q == ST_MUL);

    lc3_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .reset_    (reset_),
        .load_i    (mul_load),
        .step_i    (mul_step),
        .a_i       (sr1),
        .b_i       (opb_in),
        .last_o    (mul_last),
        .product_o (mul_prod)
    );
`else
    assign is_mul = 1'b0;
`endif

    // Reserved codes (and 100 without the multiplier) fall through to PASSA.
    always_comb begin
        case (aluk_q)
            ALUK_ADD: alu_res = opa_q + opb_q;
            ALUK_AND: alu_res = opa_q & opb_q;
            ALUK_NOT: alu_res = ~opa_q;
            default:  alu_res = opa_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        aluk_d   = aluk_q;
        result_d = result_q;
        nzp_d    = nzp_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opa_d   = sr1;
                    opb_d   = opb_in;
                    aluk_d  = aluk;
                    state_d = is_mul ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_res;
                nzp_d    = nzp_of(alu_res);
                state_d  = ST_DONE;
            end
`ifdef LC3_MUL_EN
            ST_MUL: begin
                if (mul_last) begin
                    result_d = mul_prod;
                    nzp_d    = nzp_of(mul_prod);
                    state_d  = ST_DONE;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q  <= ST_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            aluk_q   <= ALUK_ADD;
            result_q <= '0;
            nzp_q    <= 3'b010;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            aluk_q   <= aluk_d;
            result_q <= result_d;
            nzp_q    <= nzp_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign nzp    = nzp_q;

endmodule
